poly_voice_synth: RTL and testbench

//  N-voice polyphonic generator replacing the single oscillator/envelope/amplifier chain in the audio top.
//  Per sample_tick, one shared datapath scans every voice in turn: phase accumulate, waveform, linear AR envelope, scale.
//  The voice outputs are summed, shifted, saturated and presented as unsigned PCM to the existing dac.

---
 rtl/audio_pkg.sv | 34 +++
 rtl/voice_env.sv | 25 ++
 rtl/poly_voice_synth.sv | 235 +++++++++++++++++++++++
 tb/tb_poly_voice_synth.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared wave/config constants, scan states and increment helper for poly_voice_synth
package audio_pkg;

    localparam logic [1:0] WAVE_SAW   = 2'd0;
    localparam logic [1:0] WAVE_SQR   = 2'd1;
    localparam logic [1:0] WAVE_TRI   = 2'd2;
    localparam logic [1:0] WAVE_NOISE = 2'd3;

    localparam logic [1:0] CFG_INC  = 2'd0;
    localparam logic [1:0] CFG_WAVE = 2'd1;
    localparam logic [1:0] CFG_ATK  = 2'd2;
    localparam logic [1:0] CFG_REL  = 2'd3;

    localparam int SAMPLE_RATE_HZ = 31250;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_MIX  = 2'd2
    } scan_state_t;

    // Phase increment for a tone of hz at the fixed sample rate; clamps to the 16-bit register range.
    function automatic logic [15:0] calc_increment(input int unsigned hz, input int unsigned phase_width);
        logic [63:0] num;
        logic [63:0] quo;
        num = 64'(hz) << phase_width;
        quo = num / 64'(SAMPLE_RATE_HZ);
        if (quo > 64'd65535) begin
            return 16'hFFFF;
        end
        return quo[15:0];
    endfunction

endpackage

// File: rtl/voice_env.sv
// rtl/voice_env.sv - one saturating linear attack/release step of a 16-bit envelope
module voice_env (
    input  logic [15:0] env,
    input  logic        gate,
    input  logic [7:0]  attack,
    input  logic [7:0]  rel,
    output logic [15:0] env_next
);

    logic [16:0] rise;
    logic [16:0] fall;

    // Rates are scaled by 256; a carry or borrow out of bit 15 clamps to the rail, rate 0 holds.
    always_comb begin
        rise = {1'b0, env} + {1'b0, attack, 8'h00};
        fall = {1'b0, env} - {1'b0, rel, 8'h00};
        env_next = env;
        if (gate) begin
            env_next = rise[16] ? 16'hFFFF : rise[15:0];
        end else begin
            env_next = fall[16] ? 16'h0000 : fall[15:0];
        end
    end

endmodule

// File: rtl/poly_voice_synth.sv
// rtl/poly_voice_synth.sv - N-voice scanned oscillator/envelope/mixer; noise wave enabled by POLY_NOISE_EN
module poly_voice_synth
    import audio_pkg::*;
#(
    parameter int VOICES      = 4,
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 6,
    parameter int MIX_SHIFT   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic [VOICES-1:0]          gate,
    input  logic                       cfg_we,
    input  logic [$clog2(VOICES)-1:0]  cfg_voice,
    input  logic [1:0]                 cfg_addr,
    input  logic [15:0]                cfg_wdata,
    output logic [BITDEPTH-1:0]        pcm,
    output logic                       pcm_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int PW = BITDEPTH + BITFRACTION;
    localparam int VW = $clog2(VOICES);
    localparam int AW = BITDEPTH + VW;

    localparam logic signed [AW-1:0] SAT_MAX = {{(VW+1){1'b0}}, {(BITDEPTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(VW+1){1'b1}}, {(BITDEPTH-1){1'b0}}};

    logic [15:0]         inc_r   [VOICES];
    logic [1:0]          wave_r  [VOICES];
    logic [7:0]          atk_r   [VOICES];
    logic [7:0]          rel_r   [VOICES];
    logic [PW-1:0]       phase_r [VOICES];
    logic [15:0]         env_r   [VOICES];

    scan_state_t         state_r;
    scan_state_t         state_n;
    logic                start_scan;
    logic                scan_en;
    logic [VW-1:0]       scan_idx;
    logic                last_voice;
    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] acc_next;

    logic [PW-1:0]       cur_phase;
    logic [15:0]         cur_inc;
    logic [1:0]          cur_wave;
    logic [7:0]          cur_atk;
    logic [7:0]          cur_rel;
    logic [15:0]         cur_env;
    logic                cur_gate;
    logic [15:0]         env_next;

    logic [BITDEPTH-1:0] tri_base;
    logic [BITDEPTH-1:0] wave_w;
    logic [BITDEPTH-1:0] noise_w;
    logic signed [BITDEPTH+8:0] centred_x;
    logic signed [BITDEPTH+8:0] level_x;
    logic signed [BITDEPTH+8:0] prod;
    logic signed [AW-1:0] voice_s;
    logic signed [AW-1:0] mixed;
    logic [BITDEPTH-1:0] sat;
    logic [BITDEPTH-1:0] pcm_next;
    logic                unused_bits;

    assign last_voice = (scan_idx == VW'(VOICES - 1));

    assign cur_phase = phase_r[scan_idx];
    assign cur_inc   = inc_r[scan_idx];
    assign cur_wave  = wave_r[scan_idx];
    assign cur_atk   = atk_r[scan_idx];
    assign cur_rel   = rel_r[scan_idx];
    assign cur_env   = env_r[scan_idx];
    assign cur_gate  = gate[scan_idx];

`ifdef POLY_NOISE_EN
    logic [15:0]            lfsr_r;
    logic [BITDEPTH+15:0]   noise_pad;

    // Fibonacci LFSR (taps 16,14,13,11) stepped once per finished sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r <= 16'hACE1;
        end else if (state_r == ST_MIX) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign noise_pad   = {lfsr_r, {BITDEPTH{1'b0}}};
    assign noise_w     = noise_pad[BITDEPTH+15 -: BITDEPTH];
    assign unused_bits = ^{noise_pad[15:0], prod[7:0], prod[BITDEPTH+8]};
`else
    assign noise_w     = {1'b1, {(BITDEPTH-1){1'b0}}};
    assign unused_bits = ^{prod[7:0], prod[BITDEPTH+8]};
`endif

    // Shared envelope step for whichever voice is being scanned.
    voice_env u_env (
        .env      (cur_env),
        .gate     (cur_gate),
        .attack   (cur_atk),
        .rel      (cur_rel),
        .env_next (env_next)
    );

    // Waveform select from the pre-update phase of the scanned voice.
    always_comb begin
        tri_base = {cur_phase[PW-2 -: BITDEPTH-1], 1'b0};
        wave_w   = '0;
        case (cur_wave)
            WAVE_SAW: wave_w = cur_phase[PW-1 -: BITDEPTH];
            WAVE_SQR: wave_w = {BITDEPTH{cur_phase[PW-1]}};
            WAVE_TRI: wave_w = cur_phase[PW-1] ? ~tri_base : tri_base;
            default:  wave_w = noise_w;
        endcase
    end

    // Centre the wave, scale by the envelope's top byte and accumulate; the result fits BITDEPTH bits.
    always_comb begin
        centred_x = {{9{~wave_w[BITDEPTH-1]}}, ~wave_w[BITDEPTH-1], wave_w[BITDEPTH-2:0]};
        level_x   = {{(BITDEPTH+1){1'b0}}, cur_env[15:8]};
        prod      = centred_x * level_x;
        voice_s   = {{VW{prod[BITDEPTH+7]}}, prod[BITDEPTH+7:8]};
        acc_next  = acc_r + voice_s;
    end

    // Mix: shift, clamp to the signed PCM range and move to offset binary.
    always_comb begin
        mixed = acc_next >>> MIX_SHIFT;
        if (mixed > SAT_MAX) begin
            sat = SAT_MAX[BITDEPTH-1:0];
        end else if (mixed < SAT_MIN) begin
            sat = SAT_MIN[BITDEPTH-1:0];
        end else begin
            sat = mixed[BITDEPTH-1:0];
        end
        pcm_next = {~sat[BITDEPTH-1], sat[BITDEPTH-2:0]};
    end

    // Scan state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode and scan controls; busy/pcm_valid are decodes of the registered state.
    always_comb begin
        state_n    = state_r;
        start_scan = 1'b0;
        scan_en    = 1'b0;
        busy       = 1'b1;
        pcm_valid  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
                if (sample_tick) begin
                    state_n    = ST_SCAN;
                    start_scan = 1'b1;
                end
            end
            ST_SCAN: begin
                scan_en = 1'b1;
                if (last_voice) begin
                    state_n = ST_MIX;
                end
            end
            ST_MIX: begin
                pcm_valid = 1'b1;
                state_n   = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Per-voice phase/envelope update and accumulation; pcm is captured with the last voice so it is current during MIX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r    <= '0;
            scan_idx <= '0;
            pcm      <= {1'b1, {(BITDEPTH-1){1'b0}}};
            for (int i = 0; i < VOICES; i++) begin
                phase_r[i] <= '0;
                env_r[i]   <= '0;
            end
        end else if (start_scan) begin
            acc_r    <= '0;
            scan_idx <= '0;
        end else if (scan_en) begin
            acc_r             <= acc_next;
            scan_idx          <= last_voice ? '0 : scan_idx + 1'b1;
            phase_r[scan_idx] <= cur_phase + PW'(cur_inc);
            env_r[scan_idx]   <= env_next;
            if (last_voice) begin
                pcm <= pcm_next;
            end
        end
    end

    // Config register file; the scan reads the old contents during a same-cycle write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < VOICES; i++) begin
                inc_r[i]  <= '0;
                wave_r[i] <= '0;
                atk_r[i]  <= '0;
                rel_r[i]  <= '0;
            end
        end else if (cfg_we && (32'(cfg_voice) < VOICES)) begin
            case (cfg_addr)
                CFG_INC:  inc_r[cfg_voice]  <= cfg_wdata;
                CFG_WAVE: wave_r[cfg_voice] <= cfg_wdata[1:0];
                CFG_ATK:  atk_r[cfg_voice]  <= cfg_wdata[7:0];
                default:  rel_r[cfg_voice]  <= cfg_wdata[7:0];
            endcase
        end
    end

    // Sticky flag for sample ticks that land on an active scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (sample_tick && (state_r != ST_IDLE)) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_poly_voice_synth.sv
// tb/tb_poly_voice_synth.sv - scoreboard bench for poly_voice_synth
module tb_poly_voice_synth;
    import audio_pkg::*;

    localparam int V  = 4;
    localparam int BD = 14;
    localparam int BF = 6;
    localparam int MS = 0;
    localparam int PW = BD + BF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_tick = 1'b0;
    logic [V-1:0]  gate = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_voice = '0;
    logic [1:0]    cfg_addr = '0;
    logic [15:0]   cfg_wdata = '0;
    logic [BD-1:0] pcm;
    logic          pcm_valid;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int pcm;
        int due;
    } exp_t;
    exp_t exp_q[$];

    int m_inc[V], m_wave[V], m_atk[V], m_rel[V], m_phase[V], m_env[V];
    int m_lfsr;

    poly_voice_synth #(
        .VOICES(V), .BITDEPTH(BD), .BITFRACTION(BF), .MIX_SHIFT(MS)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .gate(gate),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .pcm(pcm), .pcm_valid(pcm_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < V; i++) begin
            m_inc[i] = 0; m_wave[i] = 0; m_atk[i] = 0; m_rel[i] = 0;
            m_phase[i] = 0; m_env[i] = 0;
        end
        m_lfsr = 16'hACE1;
    endfunction

    function automatic void model_write(input int v, input int a, input int d);
        case (a)
            0: m_inc[v]  = d & 16'hFFFF;
            1: m_wave[v] = d & 3;
            2: m_atk[v]  = d & 255;
            default: m_rel[v] = d & 255;
        endcase
    endfunction

    // Reference sample: wave from current phase, scaled by current envelope, then state advance.
    function automatic int model_sample();
        int acc, w, t, s, m, e, fb;
        acc = 0;
        for (int v = 0; v < V; v++) begin
            case (m_wave[v])
                0: w = m_phase[v] >> BF;
                1: w = ((m_phase[v] >> (PW-1)) & 1) ? (1 << BD) - 1 : 0;
                2: begin
                    t = ((m_phase[v] >> BF) & ((1 << (BD-1)) - 1)) << 1;
                    w = ((m_phase[v] >> (PW-1)) & 1) ? (~t) & ((1 << BD) - 1) : t;
                end
`ifdef POLY_NOISE_EN
                default: w = m_lfsr >> (16 - BD);
`else
                default: w = 1 << (BD-1);
`endif
            endcase
            s = ((w - (1 << (BD-1))) * (m_env[v] >> 8)) >>> 8;
            acc += s;
            m_phase[v] = (m_phase[v] + m_inc[v]) & ((1 << PW) - 1);
            if (gate[v]) begin
                e = m_env[v] + m_atk[v] * 256;
                m_env[v] = (e > 65535) ? 65535 : e;
            end else begin
                e = m_env[v] - m_rel[v] * 256;
                m_env[v] = (e < 0) ? 0 : e;
            end
        end
        m = acc >>> MS;
        if (m > (1 << (BD-1)) - 1) m = (1 << (BD-1)) - 1;
        if (m < -(1 << (BD-1))) m = -(1 << (BD-1));
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
        return m + (1 << (BD-1));
    endfunction

    // Scoreboard: each pcm_valid pops one expectation and checks value and arrival cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (pcm_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_pcm_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("pcm", int'(pcm), e.pcm);
                    check_eq("pcm_valid_latency", cyc, e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check_eq("pcm_valid_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        gate = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    task automatic cfg_write(input int v, input int a, input int d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_voice = 2'(v); cfg_addr = 2'(a); cfg_wdata = 16'(d);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_write(v, a, d);
    endtask

    // One sample; optionally a config write lands in the cycle voice v is scanned.
    task automatic do_tick(input bit wr, input int v, input int a, input int d);
        exp_t e;
        @(posedge clk); #1;
        sample_tick = 1'b1;
        e.pcm = model_sample();
        e.due = cyc + V + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        sample_tick = 1'b0;
        if (wr) begin
            repeat (v) begin
                @(posedge clk); #1;
            end
            cfg_we = 1'b1; cfg_voice = 2'(v); cfg_addr = 2'(a); cfg_wdata = 16'(d);
            @(posedge clk); #1;
            cfg_we = 1'b0;
            model_write(v, a, d);
        end
        repeat (V + 3) @(posedge clk);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0, 0, 0, 0);
    endtask

    task automatic overrun_tick();
        exp_t e;
        @(posedge clk); #1;
        sample_tick = 1'b1;
        e.pcm = model_sample();
        e.due = cyc + V + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(posedge clk); #1;
        sample_tick = 1'b1;
        @(negedge clk);
        check_eq("busy_during_scan", int'(busy), 1);
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (V + 3) @(posedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        model_reset();
        do_reset();
        @(negedge clk);
        check_eq("reset_pcm", int'(pcm), 1 << (BD-1));
        check_eq("reset_pcm_valid", int'(pcm_valid), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_overrun", int'(overrun), 0);

        // Silence with all gates low
        run_ticks(10);

        // Saw on voice 0 with fastest attack
        cfg_write(0, CFG_WAVE, WAVE_SAW);
        cfg_write(0, CFG_INC, 16'h4000);
        cfg_write(0, CFG_ATK, 255);
        gate = 4'b0001;
        run_ticks(70);

        // Second tick during a scan
        overrun_tick();
        @(negedge clk);
        check_eq("overrun_set", int'(overrun), 1);
        check_eq("busy_after_scan", int'(busy), 0);
        run_ticks(1);
        @(negedge clk);
        check_eq("overrun_sticky", int'(overrun), 1);

        // Release from full level
        cfg_write(0, CFG_REL, 16);
        gate = 4'b0000;
        run_ticks(20);

        // Mid-scan writes to voice 1
        cfg_write(1, CFG_WAVE, WAVE_TRI);
        cfg_write(1, CFG_INC, 16'h1000);
        cfg_write(1, CFG_ATK, 255);
        gate = 4'b0010;
        run_ticks(4);
        do_tick(1'b1, 1, CFG_INC, 16'h3000);
        run_ticks(2);
        do_tick(1'b1, 1, CFG_WAVE, WAVE_SAW);
        run_ticks(3);

        do_reset();
        @(negedge clk);
        check_eq("overrun_cleared", int'(overrun), 0);
        check_eq("pcm_after_reset", int'(pcm), 1 << (BD-1));

        // Four in-phase squares driving the mix into saturation
        for (int v = 0; v < V; v++) begin
            cfg_write(v, CFG_WAVE, WAVE_SQR);
            cfg_write(v, CFG_INC, 16'h8000);
            cfg_write(v, CFG_ATK, 255);
        end
        gate = 4'b1111;
        run_ticks(40);

        // Wave 3: noise or silence depending on build
        do_reset();
        cfg_write(0, CFG_WAVE, WAVE_NOISE);
        cfg_write(0, CFG_ATK, 255);
        gate = 4'b0001;
        run_ticks(12);

        repeat (10) @(posedge clk);
        check_eq("queue_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
